// File: rtl/zoom_hdmi_fifo_sched.sv
// Read-side scheduler for the zoom-to-HDMI pixel FIFO.
// Keeps the FIFO topped up with upstream burst requests, flushes it at each
// frame start, serves active video from it and counts starved DE cycles.
module zoom_hdmi_fifo_sched #(
  parameter int c_RD_DEPTH_WIDTH = 8,
  parameter int c_H_ACTIVE       = 1280,
  parameter int c_V_ACTIVE       = 720,
  parameter int c_BURST_LEN      = 64,
  parameter int c_REQ_LEVEL      = 160,
  parameter int c_PREFILL_LEVEL  = 192,
  parameter int c_FLUSH_CYC      = 8
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst,
  input  logic                      vsync_in,
  input  logic                      de_in,
  output logic                      fifo_rd_en,
  input  logic                      fifo_rd_empty,
  input  logic [c_RD_DEPTH_WIDTH:0] fifo_rd_water_level,
  output logic                      fifo_flush,
  output logic                      burst_req,
  output logic [15:0]               burst_len,
  input  logic                      burst_ack,
  input  logic                      burst_done,
  output logic                      pix_valid,
  output logic [15:0]               underrun_cnt,
  output logic                      sched_busy
);

  localparam logic [23:0] c_TOTAL = 24'(c_H_ACTIVE * c_V_ACTIVE);
  localparam logic [23:0] c_BURST = 24'(c_BURST_LEN);
  localparam logic [c_RD_DEPTH_WIDTH:0] c_REQ_LVL = (c_RD_DEPTH_WIDTH + 1)'(c_REQ_LEVEL);
  localparam logic [c_RD_DEPTH_WIDTH:0] c_PRE_LVL = (c_RD_DEPTH_WIDTH + 1)'(c_PREFILL_LEVEL);
  localparam logic [7:0]  c_FLUSH_LAST = 8'(c_FLUSH_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FLUSH_WAIT = 3'd1,
    ST_FLUSH      = 3'd2,
    ST_PREFILL    = 3'd3,
    ST_RUN        = 3'd4
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [7:0]  flush_cnt_r;
  logic [23:0] req_cnt_r, rd_cnt_r, rd_cnt_nxt_s, remain_s;
  logic        burst_req_r, outstanding_r, pending_s;
  logic [15:0] burst_len_r, next_len_s, underrun_cnt_r;
  logic        pix_valid_r, fifo_flush_r, sched_busy_r;
  logic        rd_en_s, issue_s, underrun_s, serving_s;

  // Read enable, request issue decision, burst sizing and underrun detection.
  always_comb begin
    pending_s = burst_req_r | outstanding_r;
    serving_s = (state_r == ST_PREFILL) || (state_r == ST_RUN);
    if (state_r == ST_RUN) begin
      rd_en_s = de_in & ~fifo_rd_empty;
    end else begin
      rd_en_s = 1'b0;
    end
    rd_cnt_nxt_s = rd_cnt_r + {23'd0, rd_en_s};
    remain_s     = c_TOTAL - req_cnt_r;
    if (remain_s < c_BURST) begin
      next_len_s = remain_s[15:0];
    end else begin
      next_len_s = c_BURST[15:0];
    end
    // A vsync in the same cycle aborts the frame, so no fresh request then.
    issue_s = serving_s && !vsync_in && !pending_s &&
              (fifo_rd_water_level <= c_REQ_LVL) && (req_cnt_r < c_TOTAL);
    underrun_s = de_in && ((state_r == ST_PREFILL) ||
                           ((state_r == ST_RUN) && fifo_rd_empty));
  end

  // Frame sequencing: flush handshake, prefill, active service, abort on vsync.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (vsync_in) state_nxt_s = ST_FLUSH_WAIT;
        else          state_nxt_s = ST_IDLE;
      end
      ST_FLUSH_WAIT: begin
        if (!pending_s) state_nxt_s = ST_FLUSH;
        else            state_nxt_s = ST_FLUSH_WAIT;
      end
      ST_FLUSH: begin
        if (flush_cnt_r == c_FLUSH_LAST) state_nxt_s = ST_PREFILL;
        else                             state_nxt_s = ST_FLUSH;
      end
      ST_PREFILL: begin
        if (vsync_in)
          state_nxt_s = ST_FLUSH_WAIT;
        else if ((fifo_rd_water_level >= c_PRE_LVL) || (req_cnt_r == c_TOTAL))
          state_nxt_s = ST_RUN;
        else
          state_nxt_s = ST_PREFILL;
      end
      ST_RUN: begin
        if (vsync_in)                     state_nxt_s = ST_FLUSH_WAIT;
        else if (rd_cnt_nxt_s == c_TOTAL) state_nxt_s = ST_IDLE;
        else                              state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and flush-length counter.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_FLUSH) flush_cnt_r <= flush_cnt_r + 8'd1;
      else                     flush_cnt_r <= 8'd0;
    end
  end

  // Request engine: one burst in flight, from request until burst_done.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      burst_req_r   <= 1'b0;
      outstanding_r <= 1'b0;
      burst_len_r   <= 16'd0;
      req_cnt_r     <= 24'd0;
    end else begin
      if (burst_req_r && burst_ack) begin
        burst_req_r   <= 1'b0;
        outstanding_r <= 1'b1;
      end else if (issue_s) begin
        burst_req_r <= 1'b1;
        burst_len_r <= next_len_s;
      end
      // A done that coincides with the ack cannot belong to this burst.
      if (outstanding_r && burst_done) outstanding_r <= 1'b0;
      if (state_r == ST_FLUSH)
        req_cnt_r <= 24'd0;
      else if (burst_req_r && burst_ack)
        req_cnt_r <= req_cnt_r + {8'd0, burst_len_r};
    end
  end

  // Read/underrun counters and registered status outputs.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_cnt_r       <= 24'd0;
      underrun_cnt_r <= 16'd0;
      pix_valid_r    <= 1'b0;
      fifo_flush_r   <= 1'b0;
      sched_busy_r   <= 1'b0;
    end else begin
      if (state_r == ST_FLUSH) begin
        rd_cnt_r       <= 24'd0;
        underrun_cnt_r <= 16'd0;
      end else begin
        rd_cnt_r <= rd_cnt_nxt_s;
        if (underrun_s && (underrun_cnt_r != 16'hFFFF))
          underrun_cnt_r <= underrun_cnt_r + 16'd1;
      end
      pix_valid_r  <= rd_en_s;
      fifo_flush_r <= (state_nxt_s == ST_FLUSH);
      sched_busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

  assign fifo_rd_en   = rd_en_s;
  assign fifo_flush   = fifo_flush_r;
  assign burst_req    = burst_req_r;
  assign burst_len    = burst_len_r;
  assign pix_valid    = pix_valid_r;
  assign underrun_cnt = underrun_cnt_r;
  assign sched_busy   = sched_busy_r;

endmodule

// File: tb/tb_zoom_hdmi_fifo_sched.sv
// Bench for zoom_hdmi_fifo_sched with a small frame (16x4, bursts of 6).
// Surrounds the scheduler with a FIFO fill model and a randomised upstream
// reader, and tracks the expected behaviour frame-phase by frame-phase.
module tb_zoom_hdmi_fifo_sched;

  localparam int TOTAL     = 16 * 4;
  localparam int BURST     = 6;
  localparam int REQ_LVL   = 160;
  localparam int PRE_LVL   = 192;
  localparam int FLUSH_CYC = 8;

  localparam int P_IDLE = 0, P_FW = 1, P_FL = 2, P_PRE = 3, P_RUN = 4;

  logic        rd_clk = 1'b0;
  logic        rd_rst, vsync_in, de_in, fifo_rd_en, fifo_rd_empty, fifo_flush;
  logic [8:0]  fifo_rd_water_level;
  logic        burst_req, burst_ack, burst_done, pix_valid, sched_busy;
  logic [15:0] burst_len, underrun_cnt;

  zoom_hdmi_fifo_sched #(
    .c_RD_DEPTH_WIDTH(8), .c_H_ACTIVE(16), .c_V_ACTIVE(4), .c_BURST_LEN(6),
    .c_REQ_LEVEL(160), .c_PREFILL_LEVEL(192), .c_FLUSH_CYC(8)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .vsync_in(vsync_in), .de_in(de_in),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level), .fifo_flush(fifo_flush),
    .burst_req(burst_req), .burst_len(burst_len), .burst_ack(burst_ack),
    .burst_done(burst_done), .pix_valid(pix_valid),
    .underrun_cnt(underrun_cnt), .sched_busy(sched_busy)
  );

  always #5 rd_clk = ~rd_clk;

  int tests = 0, fails = 0;

  // scenario drives
  bit rst_v = 1'b1, vs_v = 1'b0, de_v = 1'b0, xack_v = 1'b0;
  int force_lvl = -1;

  // environment: FIFO fill and upstream reader
  int env_level = 0, up_state = 0, ack_wait = 0, done_wait = 0, up_len = 0;
  int done_mode = 0;

  // statistics
  int flush_seen = 0, len_sum = 0, rd_seen = 0, starved = 0;

  // reference model: frame phase plus the counters the rules talk about
  int m_ph = P_IDLE, m_fl_left = 0, m_len = 0, m_reqcnt = 0, m_rd = 0, m_und = 0;
  bit m_req = 1'b0, m_out = 1'b0, m_pv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int done_delay(input int len);
    case (done_mode)
      1:       return (len != BURST) ? 300 : int'($urandom_range(1, 4));
      2:       return 40;
      default: return int'($urandom_range(1, 12));
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit vs, input bit de, input bit emp,
                            input int lvl, input bit ack, input bit done);
    bit rd, pend, oreq, oout;
    int ocnt;
    if (rst) begin
      m_ph = P_IDLE; m_fl_left = 0; m_len = 0; m_reqcnt = 0; m_rd = 0; m_und = 0;
      m_req = 1'b0; m_out = 1'b0; m_pv = 1'b0;
    end else begin
      rd   = (m_ph == P_RUN) && de && !emp;
      oreq = m_req; oout = m_out; ocnt = m_reqcnt; pend = oreq || oout;
      m_pv = rd;
      if (de && (m_ph == P_PRE || (m_ph == P_RUN && emp)) && m_und < 65535) m_und++;
      if (rd) m_rd++;
      if (oout && done) m_out = 1'b0;
      if (oreq && ack) begin m_req = 1'b0; m_out = 1'b1; m_reqcnt = ocnt + m_len; end
      if ((m_ph == P_PRE || m_ph == P_RUN) && !vs && !pend && lvl <= REQ_LVL && ocnt < TOTAL) begin
        m_req = 1'b1;
        m_len = (TOTAL - ocnt < BURST) ? TOTAL - ocnt : BURST;
      end
      case (m_ph)
        P_IDLE: if (vs) m_ph = P_FW;
        P_FW:   if (!pend) begin m_ph = P_FL; m_fl_left = FLUSH_CYC; end
        P_FL: begin
          m_reqcnt = 0; m_rd = 0; m_und = 0; m_fl_left--;
          if (m_fl_left == 0) m_ph = P_PRE;
        end
        P_PRE: if (vs) m_ph = P_FW; else if (lvl >= PRE_LVL || ocnt == TOTAL) m_ph = P_RUN;
        P_RUN: if (vs) m_ph = P_FW; else if (m_rd == TOTAL) m_ph = P_IDLE;
        default: m_ph = P_IDLE;
      endcase
    end
  endtask

  // One clock: drive inputs at negedge, check outputs, advance model and environment.
  task automatic cycle();
    bit a, d, exp_rd;
    int water;
    @(negedge rd_clk);
    rd_rst = rst_v; vsync_in = vs_v; de_in = de_v;
    water = (force_lvl >= 0) ? force_lvl : env_level;
    fifo_rd_water_level = 9'(water);
    fifo_rd_empty = (water == 0);
    a = 1'b0; d = 1'b0;
    if (rst_v) begin
      up_state = 0;
    end else begin
      if (up_state == 2) begin
        if (done_wait == 0) begin d = 1'b1; up_state = 0; end
        else done_wait--;
      end else if (up_state == 0 && burst_req === 1'b1) begin
        ack_wait = int'($urandom_range(0, 3)); up_state = 1;
      end
      if (up_state == 1) begin
        if (ack_wait == 0) begin
          a = 1'b1; up_len = int'(burst_len); len_sum += up_len;
          done_wait = done_delay(up_len); up_state = 2;
        end else ack_wait--;
      end
    end
    burst_ack = a | xack_v; burst_done = d;
    #1;
    exp_rd = (m_ph == P_RUN) && de_v && !fifo_rd_empty;
    chk("fifo_rd_en",   32'(fifo_rd_en),   32'(exp_rd));
    chk("burst_req",    32'(burst_req),    32'(m_req));
    chk("burst_len",    32'(burst_len),    32'(m_len));
    chk("fifo_flush",   32'(fifo_flush),   32'(m_ph == P_FL));
    chk("sched_busy",   32'(sched_busy),   32'(m_ph != P_IDLE));
    chk("pix_valid",    32'(pix_valid),    32'(m_pv));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_und));
    if (fifo_flush === 1'b1) flush_seen++;
    if (fifo_rd_en === 1'b1) rd_seen++;
    if (m_ph == P_RUN && de_v && fifo_rd_empty) starved++;
    model_step(rst_v, vs_v, de_v, fifo_rd_empty, water, burst_ack, d);
    if (rst_v || fifo_flush === 1'b1) env_level = 0;
    else env_level = env_level - ((fifo_rd_en === 1'b1) ? 1 : 0) + (d ? up_len : 0);
    if (env_level < 0) env_level = 0;
  endtask

  task automatic pulse_vsync();
    vs_v = 1'b1; cycle(); vs_v = 1'b0;
  endtask

  initial begin
    int n;
    rd_rst = 1'b1; vsync_in = 1'b0; de_in = 1'b0; fifo_rd_empty = 1'b1;
    fifo_rd_water_level = 9'd0; burst_ack = 1'b0; burst_done = 1'b0;
    repeat (3) @(posedge rd_clk);

    // reset state
    rst_v = 1'b1; repeat (2) cycle();
    chk("reset_busy", 32'(sched_busy), 32'd0);
    rst_v = 1'b0; repeat (3) cycle();

    // frame 1: instant refill, steady service with 16-pixel DE bursts
    done_mode = 0; pulse_vsync(); flush_seen = 0; len_sum = 0; rd_seen = 0;
    n = 0; while (!(m_ph == P_RUN && env_level == TOTAL) && n < 2000) begin cycle(); n++; end
    chk("s1_prefill_bound", 32'(n < 2000), 32'd1);
    chk("s1_flush_len", 32'(flush_seen), 32'd8);
    chk("s1_len_sum", 32'(len_sum), 32'(TOTAL));
    n = 0; while (m_ph != P_IDLE && n < 3000) begin de_v = ((n % 24) < 16); cycle(); n++; end
    de_v = 1'b0; cycle();
    chk("s1_run_bound", 32'(n < 3000), 32'd1);
    chk("s1_reads", 32'(rd_seen), 32'(TOTAL));
    chk("s1_underrun", 32'(underrun_cnt), 32'd0);
    chk("s1_idle", 32'(sched_busy), 32'd0);

    // frame 2: last burst completes 300 cycles late, FIFO starves mid-line
    done_mode = 1; pulse_vsync();
    n = 0; while (m_ph != P_RUN && n < 2000) begin cycle(); n++; end
    chk("s2_prefill_bound", 32'(n < 2000), 32'd1);
    starved = 0;
    n = 0; while (m_ph != P_IDLE && n < 4000) begin de_v = ((n % 24) < 16); cycle(); n++; end
    de_v = 1'b0; cycle();
    chk("s2_run_bound", 32'(n < 4000), 32'd1);
    chk("s2_underrun", 32'(underrun_cnt), 32'(starved));

    // frame 3: abort while a burst is in flight; vsyncs during wait/flush ignored
    done_mode = 2; pulse_vsync();
    n = 0; while (!(up_state == 2 && m_ph == P_PRE) && n < 500) begin cycle(); n++; end
    chk("s3_pending_bound", 32'(n < 500), 32'd1);
    pulse_vsync();
    repeat (3) cycle();
    pulse_vsync();
    n = 0; while (m_ph != P_FL && n < 200) begin cycle(); n++; end
    chk("s3_wait_bound", 32'(n < 200), 32'd1);
    flush_seen = 0; len_sum = 0; rd_seen = 0; done_mode = 0;
    repeat (2) cycle();
    pulse_vsync();
    n = 0; while (m_ph != P_PRE && n < 50) begin cycle(); n++; end
    chk("s3_flush_len", 32'(flush_seen), 32'd8);
    n = 0; while (m_ph != P_IDLE && n < 3000) begin de_v = ((n % 24) < 16); cycle(); n++; end
    de_v = 1'b0; cycle();
    chk("s3_run_bound", 32'(n < 3000), 32'd1);
    chk("s3_len_sum", 32'(len_sum), 32'(TOTAL));
    chk("s3_reads", 32'(rd_seen), 32'(TOTAL));

    // frame 4: request threshold, prefill by level, reset mid-run
    force_lvl = 161; pulse_vsync();
    n = 0; while (m_ph != P_PRE && n < 100) begin cycle(); n++; end
    repeat (12) cycle();
    chk("s4_no_req_161", 32'(burst_req), 32'd0);
    force_lvl = 160; cycle(); cycle();
    chk("s4_req_160", 32'(burst_req), 32'd1);
    chk("s4_len_160", 32'(burst_len), 32'(BURST));
    force_lvl = 200;
    n = 0; while (m_ph != P_RUN && n < 20) begin cycle(); n++; end
    chk("s4_run_by_level", 32'(n < 20), 32'd1);
    force_lvl = 100;
    n = 0; while (!(m_req && m_ph == P_RUN) && n < 200) begin cycle(); n++; end
    cycle();
    chk("s5_req_before_rst", 32'(burst_req), 32'd1);
    rst_v = 1'b1; cycle(); rst_v = 1'b0; force_lvl = -1;
    xack_v = 1'b1; cycle(); xack_v = 1'b0;
    chk("s5_rst_req", 32'(burst_req), 32'd0);
    chk("s5_rst_busy", 32'(sched_busy), 32'd0);
    chk("s5_rst_len", 32'(burst_len), 32'd0);
    repeat (3) cycle();
    chk("s5_stray_ack", 32'(burst_req), 32'd0);

    // frame 5/6: random DE throughout, then an abort in RUN
    pulse_vsync();
    n = 0; while (m_ph != P_IDLE && n < 4000) begin de_v = 1'($urandom_range(0, 1)); cycle(); n++; end
    de_v = 1'b0; cycle();
    chk("s6_run_bound", 32'(n < 4000), 32'd1);
    pulse_vsync();
    n = 0; while (m_ph != P_RUN && n < 2000) begin de_v = 1'($urandom_range(0, 1)); cycle(); n++; end
    pulse_vsync();
    n = 0; while (m_ph != P_IDLE && n < 4000) begin de_v = 1'($urandom_range(0, 1)); cycle(); n++; end
    de_v = 1'b0; cycle();
    chk("s6_abort_bound", 32'(n < 4000), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
